xbar_sat_sweeper: RTL and testbench
===================================

XBAR_SAT_SWEEPER -- requirements
Module: xbar_sat_sweeper

Interface
REQ-001 Parameter N_VARS, default 4: number of crossbar input variables; legal range 1..16.
REQ-002 Parameter SETTLE, default 2: cycles an assignment is held before f_in is sampled; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to begin a sweep; sampled only in IDLE or DONE.
REQ-006 stop_on_first  input  1  sampled with start: 1 = end the sweep at the first satisfying assignment, 0 = exhaustive sweep.
REQ-007 f_in  input  1  evaluated output of the downstream combinational crossbar; treated as settled after SETTLE cycles.
REQ-008 x_out  output  N_VARS  assignment driven to the crossbar variable inputs; bit 0 is the LSB of the enumeration.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  high from sweep completion until the next accepted start or reset.
REQ-011 sat  output  1  at least one satisfying assignment was found in the last sweep.
REQ-012 model  output  N_VARS  first (lowest) satisfying assignment; 0 when sat=0.
REQ-013 sat_count  output  N_VARS+1  number of satisfying assignments found in the last sweep.

Function
REQ-014 The block SHALL implement the states IDLE, SETTLE, SAMPLE and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL have the following effects at that edge: go to SETTLE; set x_out=0; clear sat, model, sat_count and done; set busy=1; latch stop_on_first.
REQ-016 SETTLE SHALL last exactly SETTLE cycles, counted by an internal counter, and then go to SAMPLE; x_out SHALL be stable throughout.
REQ-017 SAMPLE SHALL last one cycle; at its closing edge f_in SHALL be sampled against the current x_out.
REQ-018 On a sample with f_in=1, sat_count SHALL increment by 1; if sat was 0, model SHALL load x_out and sat SHALL be set.
REQ-019 After a sample, the block SHALL go to DONE if the latched stop_on_first=1 and f_in=1, or if x_out is all ones.
REQ-020 Otherwise, after a sample, x_out SHALL increment by 1 and the state SHALL return to SETTLE.
REQ-021 Each assignment SHALL occupy SETTLE+1 cycles. With start accepted at edge E0, the sample for assignment k SHALL occur at edge E0+(k+1)*(SETTLE+1).
REQ-022 On entry to DONE: busy=0 and done=1. x_out, sat, model and sat_count SHALL hold their values until the next accepted start.
REQ-023 start SHALL be ignored while busy=1; stop_on_first SHALL be ignored except at an accepted start.
REQ-024 sat_count SHALL NOT wrap; its maximum value 2^N_VARS fits in N_VARS+1 bits.
REQ-025 x_out SHALL NOT wrap past all ones during a sweep; the all-ones assignment SHALL always be the last one evaluated.

Reset
REQ-026 While rst=1, asynchronously and regardless of clk: state=IDLE, x_out=0, busy=0, done=0, sat=0, model=0, sat_count=0, and the settle counter is 0.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep with no result retained. The first accepted start after rst deasserts SHALL begin a fresh sweep from x_out=0.

Verification (N_VARS=4, SETTLE=2, bench models the crossbar as a combinational function of x_out)
REQ-028 f_in tied to 0, start at E0, stop_on_first=0 -> done rises after edge E0+48; sat=0, model=0, sat_count=0, x_out=15.
REQ-029 f_in = (x_out==5), exhaustive -> done after E0+48; sat=1, model=5, sat_count=1.
REQ-030 f_in = (x_out>=3), stop_on_first=1 -> done after E0+12; sat=1, model=3, sat_count=1, x_out=3.
REQ-031 f_in = x_out[0], exhaustive -> sat_count=8, model=1, sat=1.
REQ-032 Start pulses repeated every cycle during a sweep -> no restart; the sweep ends at E0+48. A start issued in DONE -> results cleared and a new sweep begins.
REQ-033 rst pulsed at E0+20 during scenario REQ-029 -> all outputs are 0 immediately and the block stays in IDLE; a new start gives the REQ-029 result.

Source files
------------

// File: rtl/xbar_sat_sweeper_if.sv
// rtl/xbar_sat_sweeper_if.sv - sweep request/result and crossbar assignment signals
// master drives start/stop_on_first/f_in; slave (the sweeper) drives the rest.
interface xbar_sat_sweeper_if #(
  parameter int N_VARS = 4
);
  logic              start;
  logic              stop_on_first;
  logic              f_in;
  logic [N_VARS-1:0] x_out;
  logic              busy;
  logic              done;
  logic              sat;
  logic [N_VARS-1:0] model;
  logic [N_VARS:0]   sat_count;

  modport master (
    output start, stop_on_first, f_in,
    input  x_out, busy, done, sat, model, sat_count
  );

  modport slave (
    input  start, stop_on_first, f_in,
    output x_out, busy, done, sat, model, sat_count
  );
endinterface

// File: rtl/xbar_sat_sweeper.sv
// rtl/xbar_sat_sweeper.sv - exhaustive / first-hit SAT sweep over a crossbar's inputs
// Each assignment is held SETTLE cycles, then f_in is sampled in a one-cycle SAMPLE state.
module xbar_sat_sweeper #(
  parameter int N_VARS = 4,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst,
  xbar_sat_sweeper_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t            state_q, state_d;
  logic [N_VARS-1:0] x_q, x_d;
  logic [N_VARS-1:0] model_q, model_d;
  logic [N_VARS:0]   count_q, count_d;
  logic [7:0]        settle_q, settle_d;
  logic              sat_q, sat_d;
  logic              stop_q, stop_d;
  logic              busy_o, done_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      model_q  <= '0;
      count_q  <= '0;
      settle_q <= '0;
      sat_q    <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      model_q  <= model_d;
      count_q  <= count_d;
      settle_q <= settle_d;
      sat_q    <= sat_d;
      stop_q   <= stop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    model_d  = model_q;
    count_d  = count_q;
    settle_d = settle_q;
    sat_d    = sat_q;
    stop_d   = stop_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d  = S_SETTLE;
          x_d      = '0;
          model_d  = '0;
          count_d  = '0;
          settle_d = '0;
          sat_d    = 1'b0;
          stop_d   = bus.stop_on_first;
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = S_SAMPLE;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      S_SAMPLE: begin
        if (bus.f_in) begin
          count_d = count_q + 1'b1;
          if (!sat_q) begin
            model_d = x_q;
            sat_d   = 1'b1;
          end
        end
        // all-ones is always the final assignment, so x_out never wraps
        if ((stop_q && bus.f_in) || (&x_q)) begin
          state_d = S_DONE;
        end else begin
          x_d     = x_q + 1'b1;
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      S_SETTLE, S_SAMPLE: busy_o = 1'b1;
      S_DONE:             done_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.x_out     = x_q;
  assign bus.model     = model_q;
  assign bus.sat_count = count_q;
  assign bus.sat       = sat_q;
  assign bus.busy      = busy_o;
  assign bus.done      = done_o;
endmodule

// File: tb/tb_xbar_sat_sweeper.sv
// tb/tb_xbar_sat_sweeper.sv - scoreboard bench for xbar_sat_sweeper
// Crossbar modelled as a function of x_out; expected results derived by enumerating assignments.
module tb_xbar_sat_sweeper;
  localparam int NV = 4;
  localparam int ST = 2;

  typedef struct {
    int sat;
    int model;
    int count;
    int xfin;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   mode_r = 0;
  logic [15:0] tt = '0;
  exp_t sb[$];
  logic prev_done = 1'b0;

  xbar_sat_sweeper_if #(.N_VARS(NV)) bus ();

  xbar_sat_sweeper #(.N_VARS(NV), .SETTLE(ST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic fmodel(input int mode, input logic [15:0] t, input int k);
    case (mode)
      0:       return 1'b0;
      1:       return k == 5;
      2:       return k >= 3;
      3:       return k[0];
      default: return t[k[3:0]];
    endcase
  endfunction

  assign bus.f_in = fmodel(mode_r, tt, int'(bus.x_out));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".x_out"}, int'(bus.x_out), 0);
    check({tag, ".busy"}, int'(bus.busy), 0);
    check({tag, ".done"}, int'(bus.done), 0);
    check({tag, ".sat"}, int'(bus.sat), 0);
    check({tag, ".model"}, int'(bus.model), 0);
    check({tag, ".sat_count"}, int'(bus.sat_count), 0);
  endtask

  always @(negedge clk) begin
    if (bus.done && !prev_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.due);
        check("res.sat", int'(bus.sat), e.sat);
        check("res.model", int'(bus.model), e.model);
        check("res.sat_count", int'(bus.sat_count), e.count);
        check("res.x_out", int'(bus.x_out), e.xfin);
        check("res.busy", int'(bus.busy), 0);
      end
    end
    prev_done <= bus.done;
  end

  task automatic run_sweep(input int mode, input bit sof, input bit hammer);
    exp_t e;
    int   last;
    int   n;
    @(negedge clk);
    mode_r = mode;
    bus.start = 1'b1;
    bus.stop_on_first = sof;
    e.sat = 0; e.model = 0; e.count = 0; last = 0;
    for (int k = 0; k < (1 << NV); k++) begin
      last = k;
      if (fmodel(mode, tt, k)) begin
        e.count++;
        if (e.sat == 0) begin
          e.sat = 1;
          e.model = k;
        end
        if (sof) break;
      end
    end
    e.xfin = last;
    @(posedge clk);
    #1;
    e.due = cyc + (last + 1) * (ST + 1);
    sb.push_back(e);
    check("start.busy", int'(bus.busy), 1);
    check("start.done", int'(bus.done), 0);
    check("start.sat", int'(bus.sat), 0);
    check("start.sat_count", int'(bus.sat_count), 0);
    check("start.x_out", int'(bus.x_out), 0);
    if (!hammer) begin
      bus.start = 1'b0;
      bus.stop_on_first = 1'($urandom_range(0, 1));
    end else begin
      n = 0;
      while (n < 300) begin
        @(negedge clk);
        n++;
        if (bus.done) begin
          bus.start = 1'b0;
          break;
        end
        bus.stop_on_first = 1'($urandom_range(0, 1));
      end
      bus.start = 1'b0;
    end
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sweep_timeout: got no done expected done by cycle %0d", e.due);
      sb.delete();
    end
  endtask

  initial begin
    int e0;
    bus.start = 1'b0;
    bus.stop_on_first = 1'b0;
    #1;
    check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("idle");

    run_sweep(0, 1'b0, 1'b0);
    run_sweep(1, 1'b0, 1'b0);
    run_sweep(2, 1'b1, 1'b0);
    run_sweep(3, 1'b0, 1'b0);
    run_sweep(1, 1'b0, 1'b1);
    run_sweep(2, 1'b0, 1'b0);

    @(negedge clk);
    mode_r = 1;
    bus.start = 1'b1;
    bus.stop_on_first = 1'b0;
    @(posedge clk);
    #1;
    e0 = cyc;
    bus.start = 1'b0;
    while (cyc < e0 + 20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_reset.busy", int'(bus.busy), 0);
    check("post_reset.done", int'(bus.done), 0);
    check("post_reset.x_out", int'(bus.x_out), 0);
    run_sweep(1, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      tt = 16'($urandom);
      run_sweep(4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
